// File: rtl/digsys_pkg.sv
// Shared definitions for the digital-systems blocks: debouncer state encoding
// and a helper that sizes the stable-sample counter.
package digsys_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        PRESSED      = ST_PRESSED,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } db_state_e;

    // Width able to hold the value stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; q is d delayed by
// two clk edges. Synchronous active-high reset clears both stages.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: clocked state uses non-blocking (<=) so both stages sample the
    // pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2FF synchronizer, four-state acceptance FSM and
// registered level/strobe outputs. Optional release strobe: DEBOUNCE_FALL_PULSE_EN.
module button_debouncer
    import digsys_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          btn_sync;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q;
    logic          just_pressed_q;
    logic          rise_q;
    logic          press_accept;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // NOTE: every always_comb output gets a default first; any path that
    // forgot to assign would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign press_accept = (state_q == PRESS_WAIT) && (state_d == PRESSED);

    // Outputs are registered from the current state, so they trail the FSM by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            db_q           <= 1'b0;
            just_pressed_q <= 1'b0;
            rise_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            db_q           <= (state_q == PRESSED) || (state_q == RELEASE_WAIT);
            just_pressed_q <= press_accept;
            rise_q         <= just_pressed_q;
        end
    end

    assign db_level   = db_q;
    assign rise_pulse = rise_q;

`ifdef DEBOUNCE_FALL_PULSE_EN
    logic release_accept;
    logic just_released_q;
    logic fall_q;

    assign release_accept = (state_q == RELEASE_WAIT) && (state_d == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            just_released_q <= 1'b0;
            fall_q          <= 1'b0;
        end else begin
            just_released_q <= release_accept;
            fall_q          <= just_released_q;
        end
    end

    assign fall_pulse = fall_q;
`else
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_CYCLES=4): directed scenarios
// plus random bouncing input against a run-length reference model.
module tb_button_debouncer;

    localparam int S = 4;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic db_level;
    logic rise_pulse;
    logic fall_pulse;

    int total = 0;
    int bad   = 0;

    // Reference model: a level change is accepted once the synchronized input
    // has disagreed with the accepted level for S+1 consecutive edges; outputs
    // show the outcome one edge later.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0;
    logic m_pend_r = 1'b0, m_pend_f = 1'b0;
    logic m_db = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;

    button_debouncer #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .db_level   (db_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0;
            m_pend_r = 1'b0; m_pend_f = 1'b0;
            m_db = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            m_db     = m_lvl;
            m_rise   = m_pend_r;
            m_fall   = m_pend_f;
            m_pend_r = 1'b0;
            m_pend_f = 1'b0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == S + 1) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    if (m_lvl) m_pend_r = 1'b1;
                    else       m_pend_f = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_db", db_level, m_db);
        check("model_rise", rise_pulse, m_rise);
        check("model_fall", fall_pulse, FALL_EN & m_fall);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold;

        reset  = 1'b1;
        btn_in = 1'b0;
        ticks(3);
        check("reset_db", db_level, 1'b0);
        check("reset_rise", rise_pulse, 1'b0);
        check("reset_fall", fall_pulse, 1'b0);
        reset = 1'b0;

        // Quiet input: nothing moves.
        for (int k = 0; k < 20; k++) begin
            tick();
            check("quiet", db_level | rise_pulse | fall_pulse, 1'b0);
        end

        // Clean press: db_level and rise_pulse appear 7 edges after the sampling edge.
        btn_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("press_rise", rise_pulse, 1'(k == 8));
            check("press_db", db_level, 1'(k >= 8));
        end
        ticks(3);

        // Clean release.
        btn_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("release_fall", fall_pulse, 1'(FALL_EN && k == 8));
            check("release_db", db_level, 1'(k < 8));
            check("release_rise", rise_pulse, 1'b0);
        end
        ticks(3);

        // Short glitch (3 cycles) is rejected.
        btn_in = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) btn_in = 1'b0;
            tick();
            check("glitch", db_level | rise_pulse | fall_pulse, 1'b0);
        end

        // Press, then a 2-cycle release bounce: level held, no extra strobes.
        btn_in = 1'b1;
        ticks(12);
        check("bounce_pre_db", db_level, 1'b1);
        btn_in = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) btn_in = 1'b1;
            tick();
            check("bounce_db", db_level, 1'b1);
            check("bounce_rise", rise_pulse, 1'b0);
            check("bounce_fall", fall_pulse, 1'b0);
        end
        btn_in = 1'b0;
        ticks(12);

        // Reset during PRESS_WAIT (counter=2) with the button still held.
        btn_in = 1'b1;
        ticks(5);
        reset = 1'b1;
        tick();
        check("abort_db", db_level, 1'b0);
        check("abort_rise", rise_pulse, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("abort_rise_after", rise_pulse, 1'(k == 8));
            check("abort_db_after", db_level, 1'(k >= 8));
        end

        // Reset just before the rise strobe would appear: no strobe escapes.
        btn_in = 1'b0;
        ticks(12);
        btn_in = 1'b1;
        ticks(7);
        reset = 1'b1;
        tick();
        check("late_abort_rise", rise_pulse, 1'b0);
        reset = 1'b0;
        tick();
        check("late_abort_rise_next", rise_pulse, 1'b0);
        btn_in = 1'b0;
        ticks(12);

        // Random bouncing: segments of random level and length, rare resets.
        for (int seg = 0; seg < 150; seg++) begin
            btn_in = 1'($urandom_range(0, 1));
            hold   = int'($urandom_range(1, 9));
            reset  = ($urandom_range(0, 49) == 0);
            tick();
            reset = 1'b0;
            ticks(hold);
        end

        btn_in = 1'b0;
        ticks(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
